// File: rtl/repsub_divider.sv
// repsub_divider: sequential unsigned divider by repeated subtraction.
// Takes apart a value built by the add-and-load accumulator into quotient
// and remainder, one subtraction per clock, with a Start/Busy/Done handshake.
module repsub_divider #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             Clr,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] divisor_reg;

    // Single FSM: accepts requests in IDLE/DONE, subtracts once per clock in RUN,
    // and keeps every output registered so results hold steady after Done.
    always_ff @(posedge CLK or posedge Clr) begin
        if (Clr) begin
            state       <= IDLE;
            divisor_reg <= '0;
            Quotient    <= '0;
            Remainder   <= '0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            DivZero     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        divisor_reg <= Divisor;
                        Remainder   <= Dividend;
                        DivZero     <= 1'b0;
                        if (Divisor != '0) begin
                            Quotient <= '0;
                            Busy     <= 1'b1;
                            state    <= RUN;
                        end else begin
                            Quotient <= '1;
                            DivZero  <= 1'b1;
                            Done     <= 1'b1;
                            state    <= DONE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (Remainder >= divisor_reg) begin
                        Remainder <= Remainder - divisor_reg;
                        Quotient  <= Quotient + 1'b1;
                    end else begin
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_repsub_divider.sv
// tb_repsub_divider: directed self-checking bench for repsub_divider.
module tb_repsub_divider;

    logic       CLK = 1'b0;
    logic       Clr;
    logic       Start;
    logic [7:0] Dividend;
    logic [7:0] Divisor;
    logic [7:0] Quotient;
    logic [7:0] Remainder;
    logic       Busy;
    logic       Done;
    logic       DivZero;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    repsub_divider #(.WIDTH(8)) dut (
        .CLK      (CLK),
        .Clr      (Clr),
        .Start    (Start),
        .Dividend (Dividend),
        .Divisor  (Divisor),
        .Quotient (Quotient),
        .Remainder(Remainder),
        .Busy     (Busy),
        .Done     (Done),
        .DivZero  (DivZero)
    );

    // 10 ns clock
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_q"},  32'(Quotient),  32'd0);
        checkOutput({tag, "_r"},  32'(Remainder), 32'd0);
        checkOutput({tag, "_busy"}, 32'(Busy),    32'd0);
        checkOutput({tag, "_done"}, 32'(Done),    32'd0);
        checkOutput({tag, "_dz"}, 32'(DivZero),   32'd0);
    endtask

    // Drive operands with Start for one edge (edge 0); returns 1 ns after it.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
        Dividend = a;
        Divisor  = b;
        Start    = 1'b1;
        @(posedge CLK);
        #1;
        Start = 1'b0;
    endtask

    // Count edges until Done is seen; edges = -1 if the bound expires.
    task automatic waitDone(input int bound, output int edges, output bit busyHeld);
        bit found;
        found    = 1'b0;
        edges    = -1;
        busyHeld = 1'b1;
        for (int n = 1; n <= bound && !found; n++) begin
            @(posedge CLK);
            #1;
            if (Done) begin
                found = 1'b1;
                edges = n;
            end else if (!Busy) begin
                busyHeld = 1'b0;
            end
        end
    endtask

    // Full nonzero-divisor operation with timing and result checks.
    task automatic runAndCheck(input string tag, input logic [7:0] a, input logic [7:0] b,
                               input int expEdge, input logic [7:0] expQ,
                               input logic [7:0] expR);
        int  edges;
        bit  busyHeld;
        applyStimulus(a, b);
        checkOutput({tag, "_busy_e0"}, 32'(Busy), 32'd1);
        waitDone(300, edges, busyHeld);
        checkOutput({tag, "_done_edge"}, 32'(edges), 32'(expEdge));
        checkOutput({tag, "_busy_held"}, 32'(busyHeld), 32'd1);
        checkOutput({tag, "_q"}, 32'(Quotient), 32'(expQ));
        checkOutput({tag, "_r"}, 32'(Remainder), 32'(expR));
        checkOutput({tag, "_dz"}, 32'(DivZero), 32'd0);
        checkOutput({tag, "_busy_end"}, 32'(Busy), 32'd0);
        @(posedge CLK);
        #1;
        checkOutput({tag, "_done_pulse"}, 32'(Done), 32'd0);
        checkOutput({tag, "_q_hold"}, 32'(Quotient), 32'(expQ));
    endtask

    initial begin
        int  edges;
        bit  busyHeld;
        bit  sawDone;

        Clr      = 1'b0;
        Start    = 1'b0;
        Dividend = '0;
        Divisor  = '0;

        // Asynchronous clear before any clock edge
        #1 Clr = 1'b1;
        #1 checkAllZero("reset_async");
        @(posedge CLK);
        #1 Clr = 1'b0;
        checkAllZero("reset_idle");

        // Basic divisions and boundaries
        runAndCheck("d200_7", 8'd200, 8'd7, 29, 8'd28, 8'd4);
        runAndCheck("d5_9",   8'd5,   8'd9, 1,  8'd0,  8'd5);
        runAndCheck("d255_1", 8'd255, 8'd1, 256, 8'd255, 8'd0);
        runAndCheck("d0_1",   8'd0,   8'd1, 1,  8'd0,  8'd0);

        // Divide by zero: Done and DivZero come straight from the accepting edge
        applyStimulus(8'd42, 8'd0);
        checkOutput("dz_done", 32'(Done), 32'd1);
        checkOutput("dz_flag", 32'(DivZero), 32'd1);
        checkOutput("dz_busy", 32'(Busy), 32'd0);
        checkOutput("dz_q", 32'(Quotient), 32'd255);
        checkOutput("dz_r", 32'(Remainder), 32'd42);
        @(posedge CLK);
        #1;
        checkOutput("dz_done_clear", 32'(Done), 32'd0);
        checkOutput("dz_flag_hold", 32'(DivZero), 32'd1);
        checkOutput("dz_busy_after", 32'(Busy), 32'd0);

        // Start during RUN is ignored (edges 1..5, then Start held for edge 6)
        applyStimulus(8'd200, 8'd7);
        checkOutput("ign_dz_cleared", 32'(DivZero), 32'd0);
        repeat (5) @(posedge CLK);
        #1;
        Dividend = 8'd9;
        Divisor  = 8'd3;
        Start    = 1'b1;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        waitDone(300, edges, busyHeld);
        checkOutput("ign_done_edge", 32'(edges), 32'd23);
        checkOutput("ign_q", 32'(Quotient), 32'd28);
        checkOutput("ign_r", 32'(Remainder), 32'd4);
        @(posedge CLK);
        #1;

        // Back-to-back: Start held through the DONE cycle
        applyStimulus(8'd200, 8'd7);
        Start = 1'b1;
        waitDone(300, edges, busyHeld);
        checkOutput("b2b_first_edge", 32'(edges), 32'd29);
        checkOutput("b2b_first_q", 32'(Quotient), 32'd28);
        checkOutput("b2b_first_r", 32'(Remainder), 32'd4);
        applyStimulus(8'd100, 8'd10);
        checkOutput("b2b_accept_busy", 32'(Busy), 32'd1);
        checkOutput("b2b_accept_done", 32'(Done), 32'd0);
        checkOutput("b2b_accept_r", 32'(Remainder), 32'd100);
        waitDone(300, edges, busyHeld);
        checkOutput("b2b_second_edge", 32'(edges), 32'd11);
        checkOutput("b2b_second_q", 32'(Quotient), 32'd10);
        checkOutput("b2b_second_r", 32'(Remainder), 32'd0);
        @(posedge CLK);
        #1;

        // Clear mid-division at edge 10
        applyStimulus(8'd200, 8'd7);
        repeat (9) @(posedge CLK);
        @(posedge CLK);
        #2 Clr = 1'b1;
        #1 checkAllZero("clr_mid");
        sawDone = 1'b0;
        repeat (2) begin
            @(posedge CLK);
            #1;
            if (Done || Busy) sawDone = 1'b1;
        end
        Clr = 1'b0;
        repeat (3) begin
            @(posedge CLK);
            #1;
            if (Done || Busy) sawDone = 1'b1;
        end
        checkOutput("clr_no_done", 32'(sawDone), 32'd0);

        // Normal operation resumes after the clear
        runAndCheck("after_clr", 8'd200, 8'd7, 29, 8'd28, 8'd4);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
